// File: rtl/ccff_loader_pkg.sv
// Shared types and defaults for the CCFF chain loader.
package ccff_loader_pkg;

    // Loader control states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StCheck = 2'd2,
        StDone  = 2'd3
    } loader_state_e;

    localparam int unsigned DefaultChainLen = 1024;
    localparam int unsigned DefaultWordW    = 8;

    // Number of bits of the next word that still fit in the chain.
    function automatic int unsigned bits_to_take(input int unsigned remaining,
                                                 input int unsigned word_w);
        return (remaining < word_w) ? remaining : word_w;
    endfunction

endpackage

// File: rtl/config_word_serializer.sv
// Single-word parallel-to-serial converter, LSB first, with a loadable bit count so a
// partial final word only presents the bits that belong to the chain.
module config_word_serializer #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_BW = $clog2(WORD_W + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [CNT_BW-1:0] load_bits,
    input  logic              advance,
    output logic              bit_out,
    output logic              last_bit,
    output logic              empty
);

    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CNT_BW-1:0] rem_q, rem_d;

    // Next-state: clear beats load, load beats shift (load overlaps the last bit's shift).
    always_comb begin
        sreg_d = sreg_q;
        rem_d  = rem_q;
        if (clear) begin
            sreg_d = '0;
            rem_d  = '0;
        end else if (load) begin
            sreg_d = load_data;
            rem_d  = load_bits;
        end else if (advance && (rem_q != '0)) begin
            sreg_d = {1'b0, sreg_q[WORD_W-1:1]};
            rem_d  = rem_q - 1'b1;
        end
    end

    // Word shift register and remaining-bit count.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            sreg_q <= '0;
            rem_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            rem_q  <= rem_d;
        end
    end

    assign bit_out  = sreg_q[0];
    assign last_bit = (rem_q == CNT_BW'(1));
    assign empty    = (rem_q == '0);

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words into the CCFF scan chain, counts exactly CHAIN_LEN shifts,
// then checks that the first bit shifted has arrived at the chain tail.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = DefaultWordW,
    parameter int unsigned CHAIN_LEN = DefaultChainLen,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              config_done,
    output logic              chain_err
);

    localparam int unsigned BIT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] ChainLen  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] ChainLast = CNT_W'(CHAIN_LEN - 1);

    if (WORD_W < 2) begin : g_word_w_check
        $error("WORD_W must be at least 2");
    end
    if (CHAIN_LEN < 2) begin : g_chain_len_check
        $error("CHAIN_LEN must be at least 2");
    end

    loader_state_e state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d;   // bits accepted into the serializer this load
    logic [CNT_W-1:0] cnt_q, cnt_d;   // bits actually shifted into the chain
    logic             first_bit_q, first_bit_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             ser_clear;
    logic             ser_bit;
    logic             ser_last;
    logic             ser_empty;
    logic [BIT_W-1:0] load_bits;
    logic             in_load;
    logic             shifting;
    logic             accept;

    config_word_serializer #(
        .WORD_W (WORD_W),
        .CNT_BW (BIT_W)
    ) u_serializer (
        .prog_clk  (prog_clk),
        .pReset_n  (pReset_n),
        .clear     (ser_clear),
        .load      (accept),
        .load_data (word_data),
        .load_bits (load_bits),
        .advance   (shifting),
        .bit_out   (ser_bit),
        .last_bit  (ser_last),
        .empty     (ser_empty)
    );

    // Handshake and shift qualifiers; the final word is trimmed to what the chain still needs.
    always_comb begin
        in_load   = (state_q == StLoad);
        load_bits = BIT_W'(bits_to_take(CHAIN_LEN - 32'(acc_q), WORD_W));
        // Accept while empty, or while the last bit leaves, so words run back to back.
        word_ready = in_load && (acc_q < ChainLen) && (ser_empty || ser_last);
        shifting   = in_load && !ser_empty;
        accept     = word_valid && word_ready;
    end

    // Chain-facing and status outputs.
    always_comb begin
        ccff_shift_en = shifting;
        ccff_head     = shifting & ser_bit;
        busy          = (state_q == StLoad) || (state_q == StCheck);
        config_done   = done_q;
        chain_err     = err_q;
    end

    // Control FSM next-state, counters and integrity check.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        first_bit_d = first_bit_q;
        done_d      = done_q;
        err_d       = err_q;
        ser_clear   = 1'b0;

        if (abort) begin
            // Leave the partially loaded chain untouched; just stop and drop status.
            state_d   = StIdle;
            done_d    = 1'b0;
            err_d     = 1'b0;
            ser_clear = 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d     = StLoad;
                        acc_d       = '0;
                        cnt_d       = '0;
                        first_bit_d = 1'b0;
                        done_d      = 1'b0;
                        err_d       = 1'b0;
                        ser_clear   = 1'b1;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        acc_d = acc_q + CNT_W'(load_bits);
                    end
                    if (shifting) begin
                        if (cnt_q == '0) begin
                            first_bit_d = ser_bit;
                        end
                        if (cnt_q < ChainLen) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (cnt_q == ChainLast) begin
                            state_d = StCheck;
                        end
                    end
                end
                StCheck: begin
                    // After CHAIN_LEN shifts the first bit loaded must sit in the last CCFF.
                    done_d  = 1'b1;
                    err_d   = ccff_tail ^ first_bit_q;
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            first_bit_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            first_bit_q <= first_bit_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (16-bit and 12-bit chains) share stimulus;
// accepted words push expected head bits into per-chain queues, a monitor pops on each shift.
module tb_ccff_chain_loader;

    localparam int W  = 8;
    localparam int LA = 16;
    localparam int LB = 12;

    logic         prog_clk = 1'b0;
    logic         pReset_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         word_valid = 1'b0;
    logic [W-1:0] word_data = '0;
    logic         stuck = 1'b0;

    logic ready_a, head_a, sh_a, tail_a, busy_a, done_a, err_a;
    logic ready_b, head_b, sh_b, tail_b, busy_b, done_b, err_b;
    logic [LA-1:0] chain_a;
    logic [LB-1:0] chain_b;

    int checks = 0;
    int errors = 0;
    bit q_a[$];
    bit q_b[$];
    logic [LA-1:0] exp_a;
    logic [LB-1:0] exp_b;
    int acc_a, acc_b, shifts_a, shifts_b, stall_a, stall_b, post_a, post_b;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(LA)) u_dut_a (
        .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(ready_a),
        .ccff_head(head_a), .ccff_shift_en(sh_a), .ccff_tail(tail_a),
        .busy(busy_a), .config_done(done_a), .chain_err(err_a)
    );

    ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(LB)) u_dut_b (
        .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(ready_b),
        .ccff_head(head_b), .ccff_shift_en(sh_b), .ccff_tail(tail_b),
        .busy(busy_b), .config_done(done_b), .chain_err(err_b)
    );

    // Behavioural CCFF chains: head enters bit 0, tail is the top bit.
    always @(posedge prog_clk) begin
        if (sh_a) chain_a <= {chain_a[LA-2:0], head_a};
        if (sh_b) chain_b <= {chain_b[LB-2:0], head_b};
    end
    assign tail_a = stuck ? 1'b0 : chain_a[LA-1];
    assign tail_b = stuck ? 1'b0 : chain_b[LB-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every shift must match the next expected bit; idle LOAD cycles drive head=0.
    always @(negedge prog_clk) begin
        if (pReset_n === 1'b1) begin
            if (post_a == 1) begin
                chk("a_check_state", 32'({busy_a, sh_a, done_a}), 32'b100);
                post_a = 2;
            end else if (post_a == 2) begin
                chk("a_done_state", 32'({busy_a, done_a}), 32'b01);
                post_a = 0;
            end
            if (sh_a) begin
                chk("a_shift_expected", 32'(q_a.size() != 0), 32'd1);
                if (q_a.size() != 0) chk("a_head", 32'(head_a), 32'(q_a.pop_front()));
                shifts_a++;
                if (shifts_a == LA) post_a = 1;
            end else if (busy_a) begin
                chk("a_stall_head", 32'(head_a), 32'd0);
                if (shifts_a > 0 && shifts_a < LA) stall_a++;
            end

            if (post_b == 1) begin
                chk("b_check_state", 32'({busy_b, sh_b, done_b}), 32'b100);
                post_b = 2;
            end else if (post_b == 2) begin
                chk("b_done_state", 32'({busy_b, done_b}), 32'b01);
                post_b = 0;
            end
            if (sh_b) begin
                chk("b_shift_expected", 32'(q_b.size() != 0), 32'd1);
                if (q_b.size() != 0) chk("b_head", 32'(head_b), 32'(q_b.pop_front()));
                shifts_b++;
                if (shifts_b == LB) post_b = 1;
            end else if (busy_b) begin
                chk("b_stall_head", 32'(head_b), 32'd0);
                if (shifts_b > 0 && shifts_b < LB) stall_b++;
            end
        end
    end

    task automatic flush();
        q_a.delete();
        q_b.delete();
        acc_a = 0; acc_b = 0; shifts_a = 0; shifts_b = 0;
        stall_a = 0; stall_b = 0; post_a = 0; post_b = 0;
        exp_a = '0; exp_b = '0;
    endtask

    // Reference: the chain receives the accepted words LSB first, cut at the chain length.
    task automatic push_word(input logic [W-1:0] d);
        int n;
        n = (LA - acc_a < W) ? LA - acc_a : W;
        for (int i = 0; i < n; i++) begin
            q_a.push_back(d[i]);
            exp_a[acc_a + i] = d[i];
        end
        acc_a += n;
        n = (LB - acc_b < W) ? LB - acc_b : W;
        for (int i = 0; i < n; i++) begin
            q_b.push_back(d[i]);
            exp_b[acc_b + i] = d[i];
        end
        acc_b += n;
    endtask

    task automatic do_start();
        flush();
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
    endtask

    // Wait pre cycles, then offer a word until accepted (bounded).
    task automatic send_word(input logic [W-1:0] d, input int pre);
        int n;
        if (pre > 0) begin
            repeat (pre) @(posedge prog_clk);
            #1;
        end
        word_valid = 1'b1;
        word_data  = d;
        n = 0;
        forever begin
            @(negedge prog_clk);
            if (ready_a === 1'b1) break;
            n++;
            if (n > 50) begin
                chk("a_ready_timeout", 32'(ready_a), 32'd1);
                break;
            end
        end
        chk("b_ready", 32'(ready_b), 32'(acc_b < LB));
        push_word(d);
        @(posedge prog_clk); #1;
        word_valid = 1'b0;
    endtask

    task automatic check_load();
        logic [LA-1:0] ca;
        logic [LB-1:0] cb;
        for (int i = 0; i < LA; i++) ca[LA-1-i] = exp_a[i];
        for (int i = 0; i < LB; i++) cb[LB-1-i] = exp_b[i];
        chk("a_chain", 32'(chain_a), 32'(ca));
        chk("a_shifts", 32'(shifts_a), 32'(LA));
        chk("a_err", 32'(err_a), 32'(stuck ? exp_a[0] : 1'b0));
        chk("a_idle_outputs", 32'({busy_a, ready_a, sh_a}), 32'd0);
        chk("a_pending", 32'(q_a.size()), 32'd0);
        chk("b_chain", 32'(chain_b), 32'(cb));
        chk("b_shifts", 32'(shifts_b), 32'(LB));
        chk("b_err", 32'(err_b), 32'(stuck ? exp_b[0] : 1'b0));
        chk("b_idle_outputs", 32'({busy_b, ready_b, sh_b}), 32'd0);
        chk("b_pending", 32'(q_b.size()), 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(done_a === 1'b1 && done_b === 1'b1) && n < 80) begin
            @(negedge prog_clk);
            n++;
        end
        chk("done_seen", 32'(done_a & done_b), 32'd1);
        check_load();
        @(posedge prog_clk); #1;
    endtask

    // Two words with a given stall, a refused extra word, then completion.
    task automatic run_words(input logic [W-1:0] d0, input logic [W-1:0] d1, input int gap);
        send_word(d0, 0);
        send_word(d1, W - 1 + gap);
        word_valid = 1'b1;
        word_data  = 8'h55;
        repeat (4) begin
            @(negedge prog_clk);
            chk("a_ready_full", 32'(ready_a), 32'd0);
            chk("b_ready_full", 32'(ready_b), 32'd0);
        end
        @(posedge prog_clk); #1;
        word_valid = 1'b0;
        wait_done();
        chk("a_stall_cycles", 32'(stall_a), 32'(gap));
        chk("b_stall_cycles", 32'(stall_b), 32'(gap));
    endtask

    task automatic run_load(input logic [W-1:0] d0, input logic [W-1:0] d1, input int gap);
        do_start();
        run_words(d0, d1, gap);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        flush();
        #1;
        chk("reset_outputs_a", 32'({ready_a, head_a, sh_a, busy_a, done_a, err_a}), 32'd0);
        chk("reset_outputs_b", 32'({ready_b, head_b, sh_b, busy_b, done_b, err_b}), 32'd0);
        repeat (2) @(posedge prog_clk);
        #1 pReset_n = 1'b1;
        @(negedge prog_clk);
        chk("idle_after_reset", 32'({ready_a, busy_a, ready_b, busy_b}), 32'd0);
        @(posedge prog_clk); #1;

        // Back-to-back words, then a 3-cycle bubble between the same words.
        run_load(8'hA5, 8'h3C, 0);
        run_load(8'hA5, 8'h3C, 3);
        // Short chain drops the high nibble of the second word.
        run_load(8'hFF, 8'h0F, 0);

        // Tail stuck-at-0 with first bit 1, then recovery on the next start.
        stuck = 1'b1;
        run_load(8'hFF, 8'h0F, 0);
        do_start();
        @(negedge prog_clk);
        chk("restart_clears_a", 32'({done_a, err_a}), 32'd0);
        chk("restart_clears_b", 32'({done_b, err_b}), 32'd0);
        stuck = 1'b0;
        @(posedge prog_clk); #1;
        run_words(8'h81, 8'h7E, 1);

        // Abort on the 5th shift.
        do_start();
        send_word(8'($urandom), 0);
        repeat (4) @(posedge prog_clk);
        #1 abort = 1'b1;
        @(posedge prog_clk);
        #1 abort = 1'b0;
        @(negedge prog_clk);
        chk("abort_outputs_a", 32'({sh_a, busy_a, done_a}), 32'd0);
        chk("abort_outputs_b", 32'({sh_b, busy_b, done_b}), 32'd0);
        repeat (3) @(negedge prog_clk);
        chk("abort_shifts_a", 32'(shifts_a), 32'd5);
        chk("abort_shifts_b", 32'(shifts_b), 32'd5);
        chk("abort_ready_a", 32'(ready_a), 32'd0);
        @(posedge prog_clk); #1;
        run_load(8'($urandom), 8'($urandom), 0);

        // Asynchronous reset mid-load.
        do_start();
        send_word(8'($urandom), 0);
        repeat (3) @(posedge prog_clk);
        #3 pReset_n = 1'b0;
        #1;
        chk("async_reset_a", 32'({ready_a, head_a, sh_a, busy_a, done_a, err_a}), 32'd0);
        chk("async_reset_b", 32'({ready_b, head_b, sh_b, busy_b, done_b, err_b}), 32'd0);
        repeat (2) @(posedge prog_clk);
        #1 pReset_n = 1'b1;
        flush();
        repeat (3) begin
            @(negedge prog_clk);
            chk("post_reset_idle", 32'({ready_a, busy_a, sh_a, ready_b, busy_b}), 32'd0);
        end
        @(posedge prog_clk); #1;

        // Randomised loads with random bubbles.
        for (int k = 0; k < 4; k++) begin
            run_load(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
